mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter LATENCY, default 1, meaning wait cycles between acceptance and response (legal 0..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0 (DEPTH_WORDS*4-aligned).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port mem_read  input  1  read request.
REQ-007 SHALL have port mem_write  input  1  write request.
REQ-008 SHALL have port mem_addr  input  32  byte address.
REQ-009 SHALL have port mem_wdata  input  32  write data, already lane-aligned by initiator.
REQ-010 SHALL have port mem_wstrb  input  4  byte-lane write enables.
REQ-011 SHALL have port mem_addr_ready  input  1  initiator request valid.
REQ-012 SHALL have port mem_rdata  output  32  read data, full word, lanes not shifted.
REQ-013 SHALL have port mem_data_ready  output  1  one-cycle completion strobe.
REQ-014 SHALL have port mem_err  output  1  error flag, valid only with mem_data_ready.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP, RELEASE.
REQ-016 IDLE: request accepted at a clock edge where mem_addr_ready=1 and (mem_read|mem_write)=1; addr, wdata, wstrb, read/write captured in registers at that edge.
REQ-017 Acceptance -> WAIT when LATENCY>0, -> RESP when LATENCY=0; WAIT counts LATENCY cycles then -> RESP.
REQ-018 Request sampled in cycle c SHALL produce mem_data_ready=1 in cycle c+1+LATENCY, for exactly one cycle.
REQ-019 Input changes after acceptance SHALL be ignored; captured values alone determine the transaction.
REQ-020 Word index = (captured addr - BASE_ADDR) >> 2; addr[1:0] ignored for indexing.
REQ-021 Write SHALL update only bytes with wstrb bit set, committed on the edge entering RESP; wstrb=0000 completes with no change.
REQ-022 Read: mem_rdata SHALL hold the stored word during the RESP cycle and 32'h0 in every other cycle.
REQ-023 Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS): no storage access, mem_rdata=0, mem_err=1 in RESP cycle.
REQ-024 mem_read and mem_write both 1 at acceptance: no storage access, mem_err=1 in RESP cycle.
REQ-025 RESP -> RELEASE; RELEASE -> IDLE on the first edge with mem_addr_ready=0 (a held request SHALL NOT be accepted twice).
REQ-026 Write followed by read of the same word SHALL return the written data (no stale forwarding hazard).
REQ-027 mem_err SHALL be 0 whenever mem_data_ready=0.

Reset
REQ-028 rst=0 at a clock edge SHALL force IDLE, wait counter 0, mem_data_ready=0, mem_err=0, mem_rdata=0.
REQ-029 Reset during WAIT SHALL abort the transaction; the pending write SHALL NOT commit.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-031 State enum and word-index width helper SHALL live in shared package rv_mem_pkg.
REQ-032 Storage SHALL be sub-module mem_responder_array: one synchronous read port, one byte-strobed write port.
REQ-033 Wait counter SHALL be 4 bits.

Verification
REQ-034 LATENCY=2: write 0xDEADBEEF, wstrb 1111, addr 0x10 sampled cycle 5 -> mem_data_ready only in cycle 8, mem_err=0.
REQ-035 Then wstrb 0100, wdata 0x00AA0000 to addr 0x12, then read 0x10 -> mem_rdata=0xDEAABEEF.
REQ-036 LATENCY=0, DEPTH_WORDS=1024: read addr 0x1000 -> data_ready next cycle, mem_rdata=0, mem_err=1.
REQ-037 mem_read=mem_write=1, addr 0x20 -> mem_err=1, word 0x20 unchanged on later read.
REQ-038 mem_addr_ready held high 6 cycles after data_ready -> exactly one data_ready pulse; next request accepted only after it drops.
REQ-039 LATENCY=3: write 0x12345678 to 0x40, rst=0 in WAIT -> no data_ready; later read 0x40 returns prior contents.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the memory responder.
package rv_mem_pkg;

  // Transaction FSM: idle, latency countdown, completion strobe, wait for request drop.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StRelease
  } state_e;

  localparam int unsigned WaitCntW = 4;

  // Bits needed to index a word array of the given depth (at least one).
  function automatic int unsigned idx_width(input int unsigned depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word storage: one synchronous read port, one byte-strobed write port. Never cleared.
module mem_responder_array
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = idx_width(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic [3:0]       i_wstrb
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Byte-lane write; lanes with a clear strobe keep their old contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read; holds its value until the next enabled read.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory target with fixed response latency and range/conflict errors.
module mem_responder
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        mem_addr_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_data_ready,
  output logic        mem_err
);

  localparam int unsigned IdxW = idx_width(DEPTH_WORDS);
  localparam logic [32:0] Span = 33'(DEPTH_WORDS) << 2;
  localparam logic [WaitCntW-1:0] LatLast =
    (LATENCY == 0) ? '0 : WaitCntW'(LATENCY - 1);

  state_e r_state, w_state_next;
  logic [WaitCntW-1:0] r_cnt, w_cnt_next;

  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_read, r_write, r_err;

  logic        w_accept, w_enter_resp;
  logic [31:0] w_in_off, w_src_off, w_src_addr, w_src_wdata, w_arr_rdata;
  logic [3:0]  w_src_wstrb;
  logic        w_in_err, w_src_read, w_src_write, w_src_err;
  logic        w_we, w_re;
  logic [IdxW-1:0] w_idx;
  logic        w_unused_off;

  // Error classification on the live request; unsigned wrap makes addresses below BASE out of range.
  assign w_in_off = mem_addr - BASE_ADDR;
  assign w_in_err = ({1'b0, w_in_off} >= Span) || (mem_read && mem_write);

  // With zero latency the storage access happens on the accepting edge, so use live inputs there.
  assign w_src_addr  = (r_state == StIdle) ? mem_addr   : r_addr;
  assign w_src_wdata = (r_state == StIdle) ? mem_wdata  : r_wdata;
  assign w_src_wstrb = (r_state == StIdle) ? mem_wstrb  : r_wstrb;
  assign w_src_read  = (r_state == StIdle) ? mem_read   : r_read;
  assign w_src_write = (r_state == StIdle) ? mem_write  : r_write;
  assign w_src_err   = (r_state == StIdle) ? w_in_err   : r_err;

  assign w_src_off    = w_src_addr - BASE_ADDR;
  assign w_idx        = w_src_off[IdxW+1:2];
  assign w_unused_off = ^{w_src_off[31:IdxW+2], w_src_off[1:0]};

  // Storage is touched only on the edge entering RESP; reset on that edge aborts the access.
  assign w_enter_resp = (w_state_next == StResp) && (r_state != StResp);
  assign w_we = w_enter_resp && rst && w_src_write && !w_src_err;
  assign w_re = w_enter_resp && rst && w_src_read && !w_src_err;

  mem_responder_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IdxW)
  ) u_array (
    .clk    (clk),
    .i_re   (w_re),
    .i_raddr(w_idx),
    .o_rdata(w_arr_rdata),
    .i_we   (w_we),
    .i_waddr(w_idx),
    .i_wdata(w_src_wdata),
    .i_wstrb(w_src_wstrb)
  );

  // State and wait counter, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture the request at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      r_wstrb <= mem_wstrb;
      r_read  <= mem_read;
      r_write <= mem_write;
      r_err   <= w_in_err;
    end
  end

  // Next-state, counter and response outputs.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_accept       = 1'b0;
    mem_data_ready = 1'b0;
    mem_err        = 1'b0;
    mem_rdata      = '0;
    case (r_state)
      StIdle: begin
        if (mem_addr_ready && (mem_read || mem_write)) begin
          w_accept     = 1'b1;
          w_cnt_next   = '0;
          w_state_next = (LATENCY == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (r_cnt == LatLast) begin
          w_cnt_next   = '0;
          w_state_next = StResp;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StResp: begin
        mem_data_ready = 1'b1;
        mem_err        = r_err;
        mem_rdata      = (r_read && !r_err) ? w_arr_rdata : '0;
        w_state_next   = StRelease;
      end
      StRelease: begin
        // A request still held high must not be accepted a second time.
        if (!mem_addr_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule
